neopixel_chain: RTL and testbench

// Parametrised WS2812-class serial LED driver for a chain of NUM_LEDS pixels.

---
 rtl/neopixel_chain.sv | 153 +++++++++++++++
 tb/tb_neopixel_chain.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_chain.sv
// WS2812-class serial LED driver: streams NUM_LEDS pixels from a framebuffer
// read port, MSB first, followed by a latch gap; single-shot or continuous refresh.
`timescale 1ns/1ps
module neopixel_chain #(
  parameter int NUM_LEDS      = 16,
  parameter int BYTES_PER_LED = 3,
  parameter int ADDR_STRIDE   = 4,
  parameter int BASE_ADDR     = 0,
  parameter int ADDR_W        = 9,
  parameter int T_BIT         = 25,
  parameter int T0H           = 8,
  parameter int T1H           = 16,
  parameter int T_RST         = 1600,
  parameter bit INVERT        = 1'b0
) (
  input  logic              clk_20M,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  output logic              busy,
  output logic              frame_done,
  output logic              r_en,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [7:0]        din,
  output logic              data
);

  localparam int LED_W = (NUM_LEDS > 1)      ? $clog2(NUM_LEDS)      : 1;
  localparam int CH_W  = (BYTES_PER_LED > 1) ? $clog2(BYTES_PER_LED) : 1;
  localparam int TMR_W = $clog2(T_BIT);
  localparam int GAP_W = (T_RST > 1)         ? $clog2(T_RST)         : 1;

  localparam logic [LED_W-1:0]  LED_LAST  = LED_W'(NUM_LEDS - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(BYTES_PER_LED - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(T_BIT - 1);
  localparam logic [TMR_W-1:0]  T0H_C     = TMR_W'(T0H);
  localparam logic [TMR_W-1:0]  T1H_C     = TMR_W'(T1H);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(T_RST - 1);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] SLOT_SKIP = ADDR_W'(ADDR_STRIDE - BYTES_PER_LED + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PRIME, S_SEND, S_LATCH} state_t;

  state_t             r_state, w_next;
  logic [TMR_W-1:0]   r_timer;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift, r_next_byte;
  logic               r_cap;
  logic [CH_W-1:0]    r_ch;
  logic [LED_W-1:0]   r_led;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic               w_bit_end, w_byte_end, w_last_byte, w_frame_end, w_gap_end;
  logic               w_prefetch, w_raw, w_data_nxt, w_done_nxt, w_busy_nxt, w_launch;

  assign w_bit_end   = (r_state == S_SEND) && (r_timer == TMR_LAST);
  assign w_byte_end  = w_bit_end && (r_bit == 3'd7);
  assign w_last_byte = (r_led == LED_LAST) && (r_ch == CH_LAST);
  assign w_frame_end = w_byte_end && w_last_byte;
  assign w_gap_end   = (r_state == S_LATCH) && (r_gap == GAP_LAST);
  // Next byte is requested at the very start of the current one, leaving a whole byte time of slack.
  assign w_prefetch  = (r_state == S_SEND) && (r_timer == '0) && (r_bit == 3'd0) && !w_last_byte;

  // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_PRIME;
      S_PRIME: w_next = S_SEND;
      S_SEND:  if (w_frame_end) w_next = S_LATCH;
      S_LATCH: if (w_gap_end) w_next = continuous ? S_FETCH : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_raw      = r_timer < (r_shift[7] ? T1H_C : T0H_C);
    w_data_nxt = (r_state == S_SEND) ? (w_raw ^ INVERT) : INVERT;
    w_gap_nxt  = (r_state == S_LATCH && !w_gap_end) ? r_gap + GAP_W'(1) : '0;
    w_done_nxt = (w_next == S_LATCH) && (w_gap_nxt == GAP_LAST);
    w_busy_nxt = (w_next != S_IDLE);
    w_launch   = (w_next == S_FETCH);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_20M) begin
    if (rst) begin
      r_state     <= S_IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      r_en        <= 1'b0;
      r_addr      <= ADDR_BASE;
      data        <= INVERT;
      r_timer     <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_next_byte <= '0;
      r_cap       <= 1'b0;
      r_ch        <= '0;
      r_led       <= '0;
      r_gap       <= '0;
    end else begin
      r_state    <= w_next;
      busy       <= w_busy_nxt;
      frame_done <= w_done_nxt;
      data       <= w_data_nxt;
      r_gap      <= w_gap_nxt;
      r_en       <= 1'b0;
      r_cap      <= r_en;
      if (r_cap) r_next_byte <= din;

      if (w_launch) begin
        r_en   <= 1'b1;
        r_addr <= ADDR_BASE;
        r_ch   <= '0;
        r_led  <= '0;
      end

      if (w_prefetch) begin
        r_en   <= 1'b1;
        r_addr <= (r_ch == CH_LAST) ? r_addr + SLOT_SKIP : r_addr + ADDR_W'(1);
      end

      if (r_state == S_PRIME) begin
        r_shift <= din;
        r_timer <= '0;
        r_bit   <= '0;
      end else if (r_state == S_SEND) begin
        if (w_bit_end) begin
          r_timer <= '0;
          if (r_bit == 3'd7) begin
            r_bit <= '0;
            if (!w_last_byte) begin
              r_shift <= r_next_byte;
              if (r_ch == CH_LAST) begin
                r_ch  <= '0;
                r_led <= r_led + LED_W'(1);
              end else begin
                r_ch <= r_ch + CH_W'(1);
              end
            end
          end else begin
            r_bit   <= r_bit + 3'd1;
            r_shift <= {r_shift[6:0], 1'b0};
          end
        end else begin
          r_timer <= r_timer + TMR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_neopixel_chain.sv
// Bench for neopixel_chain: RGB/non-inverted and RGBW/inverted instances, checked
// against a pixel-stream model built from the framebuffer contents.
`timescale 1ns/1ps
module tb_neopixel_chain;

  localparam int T_BIT = 25, T0H = 8, T1H = 16, T_RST = 1600;
  localparam int NA = 2, BA = 3, SA = 4;
  localparam int NB = 2, BB = 4, SB = 4;

  logic clk_20M = 1'b0;
  always #25 clk_20M = ~clk_20M;

  logic rst, start, continuous, sel;
  logic busy_a, done_a, ren_a, data_a, busy_b, done_b, ren_b, data_b;
  logic [8:0] addr_a, addr_b;
  logic [7:0] din_a, din_b;
  logic [7:0] fb_a [512];
  logic [7:0] fb_b [512];
  logic [8:0] aq_a [$];
  logic [8:0] aq_b [$];

  int n_tests = 0, n_fail = 0;

  neopixel_chain #(.NUM_LEDS(NA), .BYTES_PER_LED(BA), .ADDR_STRIDE(SA), .INVERT(1'b0)) u_rgb (
    .clk_20M(clk_20M), .rst(rst), .start(start & ~sel), .continuous(continuous & ~sel),
    .busy(busy_a), .frame_done(done_a), .r_en(ren_a), .r_addr(addr_a), .din(din_a), .data(data_a));

  neopixel_chain #(.NUM_LEDS(NB), .BYTES_PER_LED(BB), .ADDR_STRIDE(SB), .INVERT(1'b1)) u_rgbw (
    .clk_20M(clk_20M), .rst(rst), .start(start & sel), .continuous(continuous & sel),
    .busy(busy_b), .frame_done(done_b), .r_en(ren_b), .r_addr(addr_b), .din(din_b), .data(data_b));

  // Framebuffer with one-cycle read latency, plus a log of every read address.
  always @(posedge clk_20M) begin
    if (ren_a) begin din_a <= fb_a[addr_a]; aq_a.push_back(addr_a); end
    if (ren_b) begin din_b <= fb_b[addr_b]; aq_b.push_back(addr_b); end
  end

  logic w_data, w_done, w_busy, w_ren;
  logic [8:0] w_addr;
  assign w_data = sel ? data_b : data_a;
  assign w_done = sel ? done_b : done_a;
  assign w_busy = sel ? busy_b : busy_a;
  assign w_ren  = sel ? ren_b  : ren_a;
  assign w_addr = sel ? addr_b : addr_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_20M);
  endtask

  function automatic logic act();
    return w_data ^ sel;
  endfunction

  function automatic int n_bytes();
    return sel ? NB * BB : NA * BA;
  endfunction

  function automatic int exp_addr(input int i);
    int bpl = sel ? BB : BA;
    int st  = sel ? SB : SA;
    return (i / bpl) * st + (i % bpl);
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    return sel ? fb_b[exp_addr(i)] : fb_a[exp_addr(i)];
  endfunction

  task automatic randomize_fb();
    for (int k = 0; k < 512; k++) begin
      fb_a[k] = 8'($urandom);
      fb_b[k] = 8'($urandom);
    end
  endtask

  task automatic check_addrs();
    logic [8:0] q [$];
    if (sel) begin q = aq_b; aq_b.delete(); end
    else     begin q = aq_a; aq_a.delete(); end
    check("addr_count", q.size(), n_bytes());
    for (int j = 0; j < q.size() && j < n_bytes(); j++) check("read_addr", q[j], exp_addr(j));
  endtask

  // Raise start at a negedge and count edges until data first goes active.
  task automatic start_frame();
    int cnt = 0;
    start = 1'b1;
    do begin
      @(posedge clk_20M);
      cnt++;
      step();
      start = 1'b0;
    end while (!act() && cnt < 50);
    check("first_rise_edges", cnt - 1, 3);
    check("busy_in_frame", w_busy, 1);
  endtask

  // Entered on the first active cycle of a frame; returns at the frame_done cycle.
  task automatic measure_frame(input int drop_at, input int poke_at);
    int h, l, nbits;
    logic [7:0] b;
    logic eb, early;
    early = 1'b0;
    nbits = n_bytes() * 8;
    for (int i = 0; i < nbits; i++) begin
      b  = exp_byte(i / 8);
      eb = b[7 - (i % 8)];
      if (i == drop_at) continuous = 1'b0;
      if (i == poke_at) start = 1'b1;
      h = 0;
      while (act() && h < T_BIT + 2) begin
        if (w_done) early = 1'b1;
        h++;
        step();
        start = 1'b0;
      end
      check("bit_high", h, eb ? T1H : T0H);
      l = 0;
      if (i < nbits - 1) begin
        while (!act() && l < T_BIT + 2) begin
          if (w_done) early = 1'b1;
          l++;
          step();
        end
        check("bit_period", h + l, T_BIT);
      end else begin
        while (!w_done && l < T_BIT + T_RST + 5) begin
          if (act()) early = 1'b1;
          l++;
          step();
        end
        check("done_seen", w_done, 1);
        check("done_level", act(), 0);
        check("tail_low", l + 1, T_BIT - h + T_RST - 1);
      end
    end
    check("no_stray_activity", early, 0);
    check_addrs();
  endtask

  // At the frame_done cycle of a single-shot frame: start there must be refused.
  task automatic finish_single();
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_done", w_busy, 0);
    check("done_width", w_done, 0);
    check("idle_level", w_data, sel);
    check("ren_idle", w_ren, 0);
    step();
    check("start_on_done_ignored", w_busy, 0);
  endtask

  task automatic finish_continuous();
    int k = 0;
    step();
    check("busy_between_frames", w_busy, 1);
    check("done_width_cont", w_done, 0);
    while (!act() && k < 10) begin k++; step(); end
    check("restart_low", k, 3);
  endtask

  initial begin
    logic quiet;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; sel = 1'b0;
    randomize_fb();
    repeat (3) @(posedge clk_20M);
    step();
    rst = 1'b0;
    check("rst_busy_a", busy_a, 0); check("rst_done_a", done_a, 0); check("rst_ren_a", ren_a, 0);
    check("rst_addr_a", addr_a, 0); check("rst_data_a", data_a, 0);
    check("rst_busy_b", busy_b, 0); check("rst_ren_b", ren_b, 0); check("rst_data_b", data_b, 1);
    aq_a.delete(); aq_b.delete();

    // Known frame on the RGB chain.
    fb_a[0] = 8'h80; fb_a[1] = 8'h01; fb_a[2] = 8'hFF;
    fb_a[4] = 8'h00; fb_a[5] = 8'hAA; fb_a[6] = 8'h55;
    start_frame(); measure_frame(-1, -1); finish_single();

    // Random frame with a start pulse while busy.
    randomize_fb();
    start_frame(); measure_frame(-1, 10); finish_single();

    // Continuous refresh, start poke in frame 2, continuous dropped mid frame 3.
    randomize_fb();
    continuous = 1'b1;
    start_frame(); measure_frame(-1, -1); finish_continuous();
    measure_frame(-1, 5); finish_continuous();
    measure_frame($urandom_range(1, NA * BA * 8 - 2), -1); finish_single();

    // Reset in the middle of a frame, then replay from the base address.
    randomize_fb();
    start_frame();
    repeat ($urandom_range(100, 900)) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", w_busy, 0); check("midrst_data", w_data, 0);
    check("midrst_ren", w_ren, 0); check("midrst_done", w_done, 0);
    aq_a.delete();
    quiet = 1'b0;
    repeat (5) begin step(); if (act() || w_ren || w_busy) quiet = 1'b1; end
    check("midrst_quiet", quiet, 0);
    start_frame(); measure_frame(-1, -1); finish_single();

    // RGBW, inverted output.
    sel = 1'b1;
    step();
    randomize_fb();
    start_frame(); measure_frame(-1, -1); finish_single();
    continuous = 1'b1;
    start_frame(); measure_frame(-1, -1); finish_continuous();
    measure_frame(3, -1); finish_single();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
